// File: rtl/id_decode_stage.sv
// Instruction decode stage: opcode to one-hot select, register/immediate extraction,
// and the ID/EX pipeline register with stall, flush and one-bubble load-use interlock.
module id_decode_stage #(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned OPC_COUNT = 20
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_instr,
   input  logic [XLEN-1:0]      in_pc,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OPC_COUNT-1:0] out_sel,
   output logic [4:0]           out_rd,
   output logic [4:0]           out_rs1,
   output logic [4:0]           out_rs2,
   output logic [XLEN-1:0]      out_imm,
   output logic [XLEN-1:0]      out_pc,
   output logic                 out_wb_en,
   output logic                 out_illegal
);

   localparam int unsigned NOP_BIT  = 11;
   localparam int unsigned LOAD_BIT = 2;

   logic [4:0]           opcode;
   logic                 dec_legal;
   logic [OPC_COUNT-1:0] dec_sel;
   logic                 dec_reads_rs1;
   logic                 dec_reads_rs2;
   logic                 dec_wb_en;
   logic [XLEN-1:0]      dec_imm;
   logic                 hazard;

   logic                 valid_d,   valid_q;
   logic [OPC_COUNT-1:0] sel_d,     sel_q;
   logic [4:0]           rd_d,      rd_q;
   logic [4:0]           rs1_d,     rs1_q;
   logic [4:0]           rs2_d,     rs2_q;
   logic [XLEN-1:0]      imm_d,     imm_q;
   logic [XLEN-1:0]      pc_d,      pc_q;
   logic                 wb_en_d,   wb_en_q;
   logic                 illegal_d, illegal_q;

   always_comb begin
      opcode    = in_instr[31:27];
      dec_legal = (32'(opcode) < OPC_COUNT);
      dec_sel   = '0;
      for (int unsigned i = 0; i < OPC_COUNT; i++) begin
         dec_sel[i] = dec_legal && (32'(opcode) == i);
      end
      // Illegal opcodes execute as NOP so the execute muxes always see a one-hot select
      if (!dec_legal) begin
         dec_sel[NOP_BIT] = 1'b1;
      end
      dec_reads_rs1 = dec_legal &&
                      (opcode inside {[5'd0:5'd10], 5'd12, [5'd14:5'd19]});
      dec_reads_rs2 = dec_legal &&
                      (opcode inside {5'd0, 5'd1, [5'd3:5'd6], [5'd14:5'd19]});
      dec_wb_en     = dec_legal && !(opcode inside {5'd3, 5'd11, [5'd14:5'd17]});
      dec_imm       = {{(XLEN-17){in_instr[16]}}, in_instr[16:0]};
   end

   always_comb begin
      hazard = valid_q && sel_q[LOAD_BIT] && in_valid && (rd_q != 5'd0) &&
               ((dec_reads_rs1 && (in_instr[21:17] == rd_q)) ||
                (dec_reads_rs2 && (in_instr[16:12] == rd_q)));
      in_ready = rst_n && !flush && (!valid_q || out_ready) && !hazard;
   end

   always_comb begin
      valid_d   = valid_q;
      sel_d     = sel_q;
      rd_d      = rd_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      imm_d     = imm_q;
      pc_d      = pc_q;
      wb_en_d   = wb_en_q;
      illegal_d = illegal_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (in_valid && in_ready) begin
         valid_d   = 1'b1;
         sel_d     = dec_sel;
         rd_d      = in_instr[26:22];
         rs1_d     = in_instr[21:17];
         rs2_d     = in_instr[16:12];
         imm_d     = dec_imm;
         pc_d      = in_pc;
         wb_en_d   = dec_wb_en;
         illegal_d = !dec_legal;
      end else if (out_ready && (hazard || !in_valid)) begin
         // Bubble: only valid drops, payload is left stale
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         sel_q     <= '0;
         rd_q      <= '0;
         rs1_q     <= '0;
         rs2_q     <= '0;
         imm_q     <= '0;
         pc_q      <= '0;
         wb_en_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         sel_q     <= sel_d;
         rd_q      <= rd_d;
         rs1_q     <= rs1_d;
         rs2_q     <= rs2_d;
         imm_q     <= imm_d;
         pc_q      <= pc_d;
         wb_en_q   <= wb_en_d;
         illegal_q <= illegal_d;
      end
   end

   assign out_valid   = valid_q;
   assign out_sel     = sel_q;
   assign out_rd      = rd_q;
   assign out_rs1     = rs1_q;
   assign out_rs2     = rs2_q;
   assign out_imm     = imm_q;
   assign out_pc      = pc_q;
   assign out_wb_en   = wb_en_q;
   assign out_illegal = illegal_q;

endmodule

// File: tb/tb_id_decode_stage.sv
// Scoreboard bench for id_decode_stage: directed hazard/stall/flush/reset cases plus a stream.
module tb_id_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [19:0] out_sel;
   logic [4:0]  out_rd, out_rs1, out_rs2;
   logic [31:0] out_imm, out_pc;
   logic        out_wb_en, out_illegal;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned st;

   typedef struct {
      logic [19:0] sel;
      logic [4:0]  rd, rs1, rs2;
      logic [31:0] imm, pc;
      logic        wb, ill;
   } exp_t;

   exp_t sb_q[$];

   id_decode_stage #(.XLEN(32), .OPC_COUNT(20)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_sel(out_sel), .out_rd(out_rd), .out_rs1(out_rs1),
      .out_rs2(out_rs2), .out_imm(out_imm), .out_pc(out_pc), .out_wb_en(out_wb_en),
      .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] enc(input int unsigned op, input int unsigned rd,
                                       input int unsigned rs1, input int unsigned rs2,
                                       input logic [16:0] imm);
      logic [31:0] w;
      w = {5'(op), 5'(rd), 5'(rs1), 17'd0};
      w[16:0] = 17'(rs2 << 12) | imm;
      return w;
   endfunction

   function automatic exp_t model(input logic [31:0] instr, input logic [31:0] pc);
      exp_t e;
      int unsigned op;
      op    = 32'(instr[31:27]);
      e.ill = (op >= 20);
      e.sel = e.ill ? 20'h00800 : (20'h1 << op);
      e.wb  = !e.ill && !(op == 3 || op == 11 || (op >= 14 && op <= 17));
      e.rd  = instr[26:22];
      e.rs1 = instr[21:17];
      e.rs2 = instr[16:12];
      e.imm = {{15{instr[16]}}, instr[16:0]};
      e.pc  = pc;
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n || flush) begin
         sb_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               check_eq("sb_spurious_out", {32'd0, out_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               e = sb_q.pop_front();
               check_eq("sb_sel", 64'(out_sel), 64'(e.sel));
               check_eq("sb_rd", 64'(out_rd), 64'(e.rd));
               check_eq("sb_rs1", 64'(out_rs1), 64'(e.rs1));
               check_eq("sb_rs2", 64'(out_rs2), 64'(e.rs2));
               check_eq("sb_imm", 64'(out_imm), 64'(e.imm));
               check_eq("sb_pc", 64'(out_pc), 64'(e.pc));
               check_eq("sb_wb", 64'(out_wb_en), 64'(e.wb));
               check_eq("sb_illegal", 64'(out_illegal), 64'(e.ill));
            end
         end
         if (in_valid && in_ready) sb_q.push_back(model(in_instr, in_pc));
      end
   end

   // Drive one instruction from posedge+1 until accepted; reports cycles spent stalled
   task automatic send(input logic [31:0] instr, input logic [31:0] pc, output int unsigned stalls);
      stalls   = 0;
      in_valid = 1'b1;
      in_instr = instr;
      in_pc    = pc;
      @(negedge clk);
      while (!in_ready && stalls < 50) begin
         @(negedge clk);
         stalls++;
      end
      if (!in_ready) check_eq("accept_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
      flush = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_in_ready", 64'(in_ready), 64'd0);
      check_eq("rst_out_sel", 64'(out_sel), 64'd0);
      check_eq("rst_out_pc", 64'(out_pc), 64'd0);
      rst_n = 1'b1;

      send(enc(0, 2, 3, 6, 17'd0), 32'h100, st);
      check_eq("add_valid", 64'(out_valid), 64'd1);
      check_eq("add_sel", 64'(out_sel), 64'h00001);
      check_eq("add_rd", 64'(out_rd), 64'd2);
      check_eq("add_rs1", 64'(out_rs1), 64'd3);
      check_eq("add_rs2", 64'(out_rs2), 64'd6);
      check_eq("add_wb", 64'(out_wb_en), 64'd1);

      // Load-use with rd=5
      send(32'h1140_0004, 32'h200, st);
      in_valid = 1'b1; in_instr = enc(0, 7, 5, 1, 17'd0); in_pc = 32'h204;
      @(negedge clk);
      check_eq("lu_stall_ready", 64'(in_ready), 64'd0);
      check_eq("lu_load_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("lu_bubble_valid", 64'(out_valid), 64'd0);
      check_eq("lu_after_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_eq("lu_dep_valid", 64'(out_valid), 64'd1);
      check_eq("lu_dep_pc", 64'(out_pc), 64'h204);

      // Load with rd=0 never interlocks
      send(enc(2, 0, 1, 0, 17'd0), 32'h210, st);
      in_valid = 1'b1; in_instr = enc(0, 7, 0, 0, 17'd0); in_pc = 32'h214;
      @(negedge clk);
      check_eq("lu0_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_eq("lu0_dep_pc", 64'(out_pc), 64'h214);

      // Back-pressure
      send(enc(1, 4, 8, 9, 17'd0), 32'h300, st);
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = enc(12, 6, 7, 0, 17'd0); in_pc = 32'h304;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("bp_in_ready", 64'(in_ready), 64'd0);
         check_eq("bp_valid", 64'(out_valid), 64'd1);
         check_eq("bp_pc", 64'(out_pc), 64'h300);
         check_eq("bp_sel", 64'(out_sel), 64'h00002);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      check_eq("bp_release_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_eq("bp_next_pc", 64'(out_pc), 64'h304);

      // Illegal opcode, then negative immediate
      send(enc(25, 3, 4, 5, 17'd0), 32'h350, st);
      check_eq("ill_sel", 64'(out_sel), 64'h00800);
      check_eq("ill_flag", 64'(out_illegal), 64'd1);
      check_eq("ill_wb", 64'(out_wb_en), 64'd0);
      send(enc(9, 1, 2, 0, 17'h1FFFF), 32'h354, st);
      check_eq("addi_imm", 64'(out_imm), 64'hFFFF_FFFF);
      check_eq("addi_sel", 64'(out_sel), 64'h00200);

      // Flush while stalled: held instruction must never reach execute
      send(enc(5, 9, 1, 2, 17'd0), 32'h400, st);
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = enc(6, 10, 1, 2, 17'd0); in_pc = 32'h404;
      @(posedge clk); #1;
      flush = 1'b1;
      @(negedge clk);
      check_eq("fl_in_ready", 64'(in_ready), 64'd0);
      check_eq("fl_held_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      check_eq("fl_after_valid", 64'(out_valid), 64'd0);
      repeat (3) @(posedge clk);
      #1;

      // Reset while stalled discards the held instruction
      send(enc(13, 11, 0, 0, 17'h00123), 32'h500, st);
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = enc(0, 1, 2, 3, 17'd0); in_pc = 32'h504;
      @(posedge clk); #1;
      rst_n = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      check_eq("rst_stall_valid", 64'(out_valid), 64'd0);
      check_eq("rst_stall_pc", 64'(out_pc), 64'd0);
      rst_n = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;

      // Back-to-back stream of every legal opcode
      for (int i = 0; i < 20; i++) begin
         send(enc(i, i + 1, (i + 10) % 32, (i + 20) % 32, 17'd0), 32'h1000 + 32'(4 * i), st);
         check_eq("stream_stalls", 64'(st), 64'd0);
      end
      check_eq("stream_last_valid", 64'(out_valid), 64'd1);
      check_eq("stream_last_sel", 64'(out_sel), 64'h80000);

      repeat (5) @(posedge clk);
      #1;
      check_eq("sb_drained", 64'(sb_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
